mips_multicycle_ctrl: RTL and testbench

Moore-style controller that sequences a multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory, and an instruction register (IR).
It decodes the opcode held in IR and steps through fetch/decode/execute/memory/writeback states.
It drives all datapath mux selects and write enables, and handshakes with a variable-latency memory through mem_req/mem_ready.
It sits between the IR opcode field and the datapath; it replaces the single-cycle decoder in the multi-cycle build.

---
 rtl/mips_mc_pkg.sv | 60 ++++++
 rtl/mc_output_decode.sv | 82 ++++++++
 rtl/mips_multicycle_ctrl.sv | 95 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// State enum, opcode constants, datapath select encodings and the packed control word.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word map; zero latency.
// pc_en/ir_write/instr_done are gated by mem_ready or zero so waits hold everything else stable.
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      // branch target is computed speculatively while the opcode is decoded
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REGB;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
        ctrl.pc_en      = (opcode == OP_BEQ) ? zero :
                          (opcode == OP_BNE) ? ~zero : 1'b0;
      end
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP:  ctrl.trap = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller: state register plus next-state logic; outputs decoded from state.
// Stalls indefinitely in FETCH/MEMRD/MEMWR until mem_ready; illegal opcodes park in TRAP until reset.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter bit ADDI_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                       state_d = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_MEMADR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
        else if (opcode == OP_J)                      state_d = S_JUMP;
        else if (opcode == OP_ADDI && ADDI_EN)        state_d = S_ADDIEX;
        else                                          state_d = S_TRAP;
      end
      // opcode cannot change after DECODE; anything else here is a corrupted IR
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_TRAP;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  mc_output_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign pc_en      = ctrl.pc_en;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign instr_done = ctrl.instr_done;
  assign trap       = ctrl.trap;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle vector walk through every instruction class, then trap and async-reset corners.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, iord, mem_write, ir_write, pc_en, alu_src_a;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, trap;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_o;

  logic       n_mem_req, n_iord, n_mem_write, n_ir_write, n_pc_en, n_alu_src_a;
  logic       n_reg_dst, n_mem_to_reg, n_reg_write, n_instr_done, n_trap;
  logic [1:0] n_pc_src, n_alu_src_b, n_alu_op;
  logic [3:0] n_state_o;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.ADDI_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .trap(trap), .state_o(state_o)
  );

  mips_multicycle_ctrl #(.ADDI_EN(1'b0)) dut_noaddi (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .iord(n_iord), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .pc_en(n_pc_en), .pc_src(n_pc_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .alu_op(n_alu_op), .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
    .instr_done(n_instr_done), .trap(n_trap), .state_o(n_state_o)
  );

  // {mem_req,iord,mem_write,ir_write,pc_en,pc_src,alu_src_a,alu_src_b,alu_op,reg_dst,mem_to_reg,reg_write,instr_done,trap}
  logic [16:0] act_out;
  assign act_out = {mem_req, iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                    alu_op, reg_dst, mem_to_reg, reg_write, instr_done, trap};

  localparam logic [16:0] O_IDLE   = 17'b0_0_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [16:0] O_FWAIT  = 17'b1_0_0_0_0_00_0_01_00_0_0_0_0_0;
  localparam logic [16:0] O_FRDY   = 17'b1_0_0_1_1_00_0_01_00_0_0_0_0_0;
  localparam logic [16:0] O_DECODE = 17'b0_0_0_0_0_00_0_11_00_0_0_0_0_0;
  localparam logic [16:0] O_MEMADR = 17'b0_0_0_0_0_00_1_10_00_0_0_0_0_0;
  localparam logic [16:0] O_MEMRD  = 17'b1_1_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [16:0] O_MEMWB  = 17'b0_0_0_0_0_00_0_00_00_0_1_1_1_0;
  localparam logic [16:0] O_WWAIT  = 17'b1_1_1_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [16:0] O_WDONE  = 17'b1_1_1_0_0_00_0_00_00_0_0_0_1_0;
  localparam logic [16:0] O_EXEC   = 17'b0_0_0_0_0_00_1_00_10_0_0_0_0_0;
  localparam logic [16:0] O_ALUWB  = 17'b0_0_0_0_0_00_0_00_00_1_0_1_1_0;
  localparam logic [16:0] O_BTAKEN = 17'b0_0_0_0_1_01_1_00_01_0_0_0_1_0;
  localparam logic [16:0] O_BNOT   = 17'b0_0_0_0_0_01_1_00_01_0_0_0_1_0;
  localparam logic [16:0] O_JUMP   = 17'b0_0_0_0_1_10_0_00_00_0_0_0_1_0;
  localparam logic [16:0] O_ADDIWB = 17'b0_0_0_0_0_00_0_00_00_0_0_1_1_0;
  localparam logic [16:0] O_TRAP   = 17'b0_0_0_0_0_00_0_00_00_0_0_0_0_1;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [16:0] out);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  initial begin
    // R-type, zero-wait memory
    add(6'd0, 0, 1, 4'd0,  O_IDLE);
    add(6'd0, 0, 1, 4'd1,  O_FRDY);
    add(6'd0, 0, 1, 4'd2,  O_DECODE);
    add(6'd0, 0, 1, 4'd7,  O_EXEC);
    add(6'd0, 0, 1, 4'd8,  O_ALUWB);
    // lw with two wait cycles in FETCH and MEMRD
    add(6'd35, 0, 0, 4'd1, O_FWAIT);
    add(6'd35, 0, 0, 4'd1, O_FWAIT);
    add(6'd35, 0, 1, 4'd1, O_FRDY);
    add(6'd35, 0, 1, 4'd2, O_DECODE);
    add(6'd35, 0, 1, 4'd3, O_MEMADR);
    add(6'd35, 0, 0, 4'd4, O_MEMRD);
    add(6'd35, 0, 0, 4'd4, O_MEMRD);
    add(6'd35, 0, 1, 4'd4, O_MEMRD);
    add(6'd35, 0, 1, 4'd5, O_MEMWB);
    // beq taken / not taken, bne not taken / taken
    add(6'd4, 1, 1, 4'd1,  O_FRDY);
    add(6'd4, 1, 0, 4'd2,  O_DECODE);
    add(6'd4, 1, 1, 4'd9,  O_BTAKEN);
    add(6'd4, 0, 1, 4'd1,  O_FRDY);
    add(6'd4, 0, 1, 4'd2,  O_DECODE);
    add(6'd4, 0, 1, 4'd9,  O_BNOT);
    add(6'd5, 1, 1, 4'd1,  O_FRDY);
    add(6'd5, 1, 1, 4'd2,  O_DECODE);
    add(6'd5, 1, 0, 4'd9,  O_BNOT);
    add(6'd5, 0, 1, 4'd1,  O_FRDY);
    add(6'd5, 0, 1, 4'd2,  O_DECODE);
    add(6'd5, 0, 1, 4'd9,  O_BTAKEN);
    // sw with three wait cycles in MEMWR
    add(6'd43, 0, 1, 4'd1, O_FRDY);
    add(6'd43, 0, 1, 4'd2, O_DECODE);
    add(6'd43, 0, 1, 4'd3, O_MEMADR);
    add(6'd43, 0, 0, 4'd6, O_WWAIT);
    add(6'd43, 0, 0, 4'd6, O_WWAIT);
    add(6'd43, 0, 0, 4'd6, O_WWAIT);
    add(6'd43, 0, 1, 4'd6, O_WDONE);
    // j, addi, then illegal opcode
    add(6'd2, 0, 1, 4'd1,  O_FRDY);
    add(6'd2, 0, 1, 4'd2,  O_DECODE);
    add(6'd2, 0, 1, 4'd10, O_JUMP);
    add(6'd8, 0, 1, 4'd1,  O_FRDY);
    add(6'd8, 0, 1, 4'd2,  O_DECODE);
    add(6'd8, 0, 1, 4'd11, O_MEMADR);
    add(6'd8, 0, 1, 4'd12, O_ADDIWB);
    add(6'd63, 0, 1, 4'd1, O_FRDY);
    add(6'd63, 0, 1, 4'd2, O_DECODE);
    add(6'd63, 0, 1, 4'd15, O_TRAP);

    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_state_async", {28'd0, state_o}, 32'd0);
    chk("reset_outs_async", {15'd0, act_out}, {15'd0, O_IDLE});
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_clocked", {28'd0, state_o}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("row%0d_state", i), {28'd0, state_o}, {28'd0, vecs[i].st});
      chk($sformatf("row%0d_outs", i), {15'd0, act_out}, {15'd0, vecs[i].out});
      @(posedge clk);
      #1;
    end

    chk("noaddi_state", {28'd0, n_state_o}, 32'd15);
    chk("noaddi_trap", {31'd0, n_trap}, 32'd1);

    // TRAP is absorbing regardless of inputs
    for (int c = 0; c < 22; c++) begin
      opcode = 6'($urandom_range(0, 63));
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("trap_hold%0d", c), {26'd0, state_o, trap, mem_req}, {26'd0, 4'd15, 1'b1, 1'b0});
      @(posedge clk);
      #1;
    end

    #2 rst_n = 1'b0;
    #1;
    chk("trap_async_rst_state", {28'd0, state_o}, 32'd0);
    chk("trap_async_rst_trap", {31'd0, trap}, 32'd0);
    chk("noaddi_async_rst_state", {28'd0, n_state_o}, 32'd0);

    // drop reset in the middle of a stalled store
    @(posedge clk);
    #1;
    opcode = 6'd43; mem_ready = 1'b1; rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midwr_state", {28'd0, state_o}, 32'd6);
    chk("midwr_mem_write", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwr_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("midwr_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midwr_rst_state", {28'd0, state_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("midwr_rst_hold", {15'd0, act_out}, {15'd0, O_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
